// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: waits for data-SRAM responses,
// extracts/merges load data, and forwards results to WB and EX.
module mem_stage #(
  parameter int unsigned ES_TO_MS_BUS_WD = 163,
  parameter int unsigned MS_TO_WS_BUS_WD = 124
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  output logic [4:0]                 ms_fwd_dest,
  output logic [31:0]                ms_fwd_data,
  output logic                       ms_fwd_blocked,
  output logic                       ms_ex_o
);

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic        req_issued;
    logic        load_op;
    logic [2:0]  load_type;
    logic [1:0]  addr_low;
    logic [31:0] rt_value;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_bus_t;

  logic        ms_valid;
  es_bus_t     es_to_ms_bus_r;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic        discard;

  logic        resp_ok;
  logic        ms_ready_go;
  logic        ms_leave;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic [3:0]  final_strb;
  ms_bus_t     ws_bus;

  // A response owed to a flushed instruction is swallowed, not consumed.
  assign resp_ok        = data_sram_data_ok & ~discard;
  assign ms_ready_go    = es_to_ms_bus_r.ex | ~es_to_ms_bus_r.req_issued | buf_valid | resp_ok;
  assign ms_allowin     = resetn & (~ms_valid | (ms_ready_go & ws_allowin));
  assign ms_leave       = ms_valid & ms_ready_go & ws_allowin;
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
  assign load_data      = buf_valid ? buf_data : data_sram_rdata;

  // Byte/half lane selection and lwl/lwr merge with the old rt value.
  always_comb begin
    byte_sel    = 8'h00;
    half_sel    = 16'h0000;
    load_result = load_data;
    case (es_to_ms_bus_r.addr_low)
      2'd0:    byte_sel = load_data[7:0];
      2'd1:    byte_sel = load_data[15:8];
      2'd2:    byte_sel = load_data[23:16];
      default: byte_sel = load_data[31:24];
    endcase
    half_sel = es_to_ms_bus_r.addr_low[1] ? load_data[31:16] : load_data[15:0];
    case (es_to_ms_bus_r.load_type)
      LD_LB:  load_result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: load_result = {24'h000000, byte_sel};
      LD_LH:  load_result = {{16{half_sel[15]}}, half_sel};
      LD_LHU: load_result = {16'h0000, half_sel};
      LD_LWL: begin
        case (es_to_ms_bus_r.addr_low)
          2'd0:    load_result = {load_data[7:0], es_to_ms_bus_r.rt_value[23:0]};
          2'd1:    load_result = {load_data[15:0], es_to_ms_bus_r.rt_value[15:0]};
          2'd2:    load_result = {load_data[23:0], es_to_ms_bus_r.rt_value[7:0]};
          default: load_result = load_data;
        endcase
      end
      LD_LWR: begin
        case (es_to_ms_bus_r.addr_low)
          2'd0:    load_result = load_data;
          2'd1:    load_result = {es_to_ms_bus_r.rt_value[31:24], load_data[31:8]};
          2'd2:    load_result = {es_to_ms_bus_r.rt_value[31:16], load_data[31:16]};
          default: load_result = {es_to_ms_bus_r.rt_value[31:8], load_data[31:24]};
        endcase
      end
      default: load_result = load_data;
    endcase
  end

  // Partial-word loads only write the bytes they merge; exceptions write nothing.
  always_comb begin
    final_strb = es_to_ms_bus_r.gr_strb;
    if (es_to_ms_bus_r.load_op && es_to_ms_bus_r.load_type == LD_LWL) begin
      case (es_to_ms_bus_r.addr_low)
        2'd0:    final_strb = 4'b1000;
        2'd1:    final_strb = 4'b1100;
        2'd2:    final_strb = 4'b1110;
        default: final_strb = 4'b1111;
      endcase
    end else if (es_to_ms_bus_r.load_op && es_to_ms_bus_r.load_type == LD_LWR) begin
      case (es_to_ms_bus_r.addr_low)
        2'd0:    final_strb = 4'b1111;
        2'd1:    final_strb = 4'b0111;
        2'd2:    final_strb = 4'b0011;
        default: final_strb = 4'b0001;
      endcase
    end
    if (es_to_ms_bus_r.ex) begin
      final_strb = 4'b0000;
    end
  end

  assign final_result = es_to_ms_bus_r.load_op ? load_result : es_to_ms_bus_r.result;

  always_comb begin
    ws_bus              = '0;
    ws_bus.excode       = es_to_ms_bus_r.excode;
    ws_bus.badvaddr     = es_to_ms_bus_r.badvaddr;
    ws_bus.cp0_addr     = es_to_ms_bus_r.cp0_addr;
    ws_bus.ex           = es_to_ms_bus_r.ex;
    ws_bus.bd           = es_to_ms_bus_r.bd;
    ws_bus.eret         = es_to_ms_bus_r.eret;
    ws_bus.syscall      = es_to_ms_bus_r.syscall;
    ws_bus.mfc0         = es_to_ms_bus_r.mfc0;
    ws_bus.mtc0         = es_to_ms_bus_r.mtc0;
    ws_bus.gr_strb      = final_strb;
    ws_bus.dest         = es_to_ms_bus_r.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = es_to_ms_bus_r.pc;
  end

  assign ms_to_ws_bus   = MS_TO_WS_BUS_WD'(ws_bus);
  assign ms_fwd_dest    = (ms_valid && es_to_ms_bus_r.gr_strb != 4'b0000) ? es_to_ms_bus_r.dest : 5'd0;
  assign ms_fwd_data    = final_result;
  assign ms_fwd_blocked = ms_valid & (es_to_ms_bus_r.mfc0 |
                          (es_to_ms_bus_r.req_issued & es_to_ms_bus_r.load_op & ~ms_ready_go));
  assign ms_ex_o        = ms_valid & (es_to_ms_bus_r.ex | es_to_ms_bus_r.eret);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid       <= 1'b0;
      es_to_ms_bus_r <= '0;
      buf_valid      <= 1'b0;
      buf_data       <= 32'h0;
      discard        <= 1'b0;
    end else begin
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (!flush && ms_allowin && es_to_ms_valid) begin
        es_to_ms_bus_r <= es_bus_t'(es_to_ms_bus);
      end

      // Hold a response that arrived while WB was not accepting.
      if (flush || ms_leave) begin
        buf_valid <= 1'b0;
      end else if (resp_ok && ms_valid && !buf_valid) begin
        buf_valid <= 1'b1;
        buf_data  <= data_sram_rdata;
      end

      // Flushed instruction still has a response in flight: swallow the next one.
      if (flush && ms_valid && es_to_ms_bus_r.req_issued && !buf_valid && !resp_ok) begin
        discard <= 1'b1;
      end else if (data_sram_data_ok && discard) begin
        discard <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB bus words are queued at stimulus
// time and compared whenever WB accepts an instruction.
module tb_mem_stage;

  localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4, LWL = 3'd5, LWR = 3'd6;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [162:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [123:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic [4:0]   ms_fwd_dest;
  logic [31:0]  ms_fwd_data;
  logic         ms_fwd_blocked;
  logic         ms_ex_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [123:0] sb[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data),
    .ms_fwd_blocked(ms_fwd_blocked), .ms_ex_o(ms_ex_o)
  );

  function automatic logic [162:0] mk_in(input logic [4:0] excode, input logic [31:0] badv,
      input logic [7:0] cp0, input logic [5:0] flags, input logic req, input logic ld,
      input logic [2:0] lt, input logic [1:0] a, input logic [31:0] rt, input logic [3:0] strb,
      input logic [4:0] dest, input logic [31:0] res, input logic [31:0] pc);
    return {excode, badv, cp0, flags, req, ld, lt, a, rt, strb, dest, res, pc};
  endfunction

  function automatic logic [123:0] mk_out(input logic [4:0] excode, input logic [31:0] badv,
      input logic [7:0] cp0, input logic [5:0] flags, input logic [3:0] strb,
      input logic [4:0] dest, input logic [31:0] res, input logic [31:0] pc);
    return {excode, badv, cp0, flags, strb, dest, res, pc};
  endfunction

  // Reference load model written with shifts and masks.
  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [1:0] a,
      input logic [31:0] rt, input logic [31:0] rd);
    logic [31:0] b, h;
    int unsigned sa;
    sa = 8 * int'(a);
    b  = (rd >> sa) & 32'hFF;
    h  = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (lt)
      LB:  return b[7] ? (b | 32'hFFFFFF00) : b;
      LBU: return b;
      LH:  return h[15] ? (h | 32'hFFFF0000) : h;
      LHU: return h;
      LWL: return (rd << (24 - sa)) | (rt & (32'hFFFFFFFF >> (sa + 8)));
      LWR: return (rd >> sa) | (rt & ~(32'hFFFFFFFF >> sa));
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] lt, input logic [1:0] a);
    logic [3:0] f;
    f = 4'b1111;
    if (lt == LWL) return f << (3 - int'(a));
    if (lt == LWR) return f >> int'(a);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every WB handshake pops one expected bus word.
  always @(negedge clk) begin
    if (resetn === 1'b1 && ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_valid bus=%h required no output", ms_to_ws_bus);
      end else begin
        logic [123:0] exp_bus;
        exp_bus = sb.pop_front();
        if (ms_to_ws_bus !== exp_bus) begin
          n_err++;
          $display("FAIL sb_bus got=%h required=%h", ms_to_ws_bus, exp_bus);
        end
      end
    end
  end

  task automatic do_load(input logic [2:0] lt, input logic [1:0] a, input logic [31:0] rt,
      input logic [31:0] rd, input logic [31:0] exp_res, input logic [3:0] exp_strb,
      input int lat, input string nm);
    logic [31:0] pc;
    logic [4:0]  dest;
    pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    dest = 5'($urandom_range(1, 31));
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_in(5'd0, 32'd0, 8'd0, 6'd0, 1'b1, 1'b1, lt, a, rt, 4'hF, dest, 32'h1000, pc);
    step();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ms_fwd_blocked !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s_wait blocked=%b valid=%b required 1/0", nm, ms_fwd_blocked, ms_to_ws_valid);
      end
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    sb.push_back(mk_out(5'd0, 32'd0, 8'd0, 6'd0, exp_strb, dest, exp_res, pc));
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b1 || ms_fwd_data !== exp_res) begin
      n_err++;
      $display("FAIL %s_out valid=%b data=%h required 1/%h", nm, ms_to_ws_valid, ms_fwd_data, exp_res);
    end
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; flush = 1'b0;
    #12;
    n_cmp++;
    if ({ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_dest, ms_fwd_data, ms_fwd_blocked, ms_ex_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs allowin=%b valid=%b bus=%h required all 0", ms_allowin, ms_to_ws_valid, ms_to_ws_bus);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release allowin=%b valid=%b required 1/0", ms_allowin, ms_to_ws_valid);
    end
    step();
  endtask

  task automatic test_loads();
    do_load(LB,  2'd2, 32'h0, 32'h80FF1234, 32'hFFFFFFFF, 4'b1111, 0, "lb_a2");
    do_load(LHU, 2'd2, 32'h0, 32'h80FF1234, 32'h000080FF, 4'b1111, 0, "lhu_a2");
    do_load(LBU, 2'd3, 32'h0, 32'h80FF1234, 32'h00000080, 4'b1111, 1, "lbu_a3");
    do_load(LWL, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344, 4'b1100, 0, "lwl_a1");
    do_load(LWR, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB, 4'b0011, 0, "lwr_a2");
    do_load(LH,  2'd0, 32'h0, 32'h80FF1234, 32'h00001234, 4'b1111, 0, "lh_a0");
    do_load(LH,  2'd2, 32'h0, 32'h80FF1234, 32'hFFFF80FF, 4'b1111, 2, "lh_a2");
    do_load(LWL, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 4'b1111, 0, "lwl_a3");
    do_load(LWR, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h112233AA, 4'b0001, 0, "lwr_a3");
  endtask

  task automatic test_random_loads();
    for (int i = 0; i < 24; i++) begin
      logic [2:0] lt;
      logic [1:0] a;
      logic [31:0] rt, rd;
      lt = 3'($urandom_range(0, 6));
      a  = 2'($urandom_range(0, 3));
      rt = $urandom;
      rd = $urandom;
      do_load(lt, a, rt, rd, ref_load(lt, a, rt, rd), ref_strb(lt, a), $urandom_range(0, 2), "rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  prev_dest;
    logic [31:0] prev_res;
    prev_dest = 5'd0; prev_res = 32'h0;
    ws_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [4:0]  dest;
      logic [31:0] res, pc;
      dest = 5'(i + 10);
      res  = $urandom;
      pc   = 32'hBFC0_0000 + 32'(i * 4);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_in(5'd0, 32'd0, 8'd0, 6'd0, 1'b0, 1'b0, LW, 2'd0, 32'h0, 4'hF, dest, res, pc);
      sb.push_back(mk_out(5'd0, 32'd0, 8'd0, 6'd0, 4'hF, dest, res, pc));
      @(negedge clk);
      n_cmp++;
      if (ms_allowin !== 1'b1 || (i > 0 && (ms_fwd_dest !== prev_dest || ms_fwd_data !== prev_res))) begin
        n_err++;
        $display("FAIL b2b_%0d allowin=%b fwd=%0d/%h required 1/%0d/%h", i, ms_allowin, ms_fwd_dest, ms_fwd_data, prev_dest, prev_res);
      end
      prev_dest = dest; prev_res = res;
      step();
    end
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ms_fwd_dest !== prev_dest || ms_fwd_data !== prev_res) begin
      n_err++;
      $display("FAIL b2b_last fwd=%0d/%h required %0d/%h", ms_fwd_dest, ms_fwd_data, prev_dest, prev_res);
    end
    step();
  endtask

  task automatic test_stall_buffer();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_in(5'd0, 32'd0, 8'd0, 6'd0, 1'b1, 1'b1, LW, 2'd0, 32'h0, 4'hF, 5'd7, 32'h2000, 32'hBFC0_0100);
    step();
    es_to_ms_valid    = 1'b0;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEADBEEF;
    sb.push_back(mk_out(5'd0, 32'd0, 8'd0, 6'd0, 4'hF, 5'd7, 32'hDEADBEEF, 32'hBFC0_0100));
    @(negedge clk);
    n_cmp++;
    if (ms_allowin !== 1'b0 || ms_fwd_blocked !== 1'b0) begin
      n_err++;
      $display("FAIL stall_resp allowin=%b blocked=%b required 0/0", ms_allowin, ms_fwd_blocked);
    end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0BAD0BAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut.buf_valid !== 1'b1 || ms_allowin !== 1'b0 || ms_fwd_blocked !== 1'b0 ||
          ms_to_ws_valid !== 1'b1 || ms_fwd_data !== 32'hDEADBEEF) begin
        n_err++;
        $display("FAIL stall_hold_%0d buf=%b allowin=%b blocked=%b valid=%b data=%h required 1/0/0/1/deadbeef",
                 i, dut.buf_valid, ms_allowin, ms_fwd_blocked, ms_to_ws_valid, ms_fwd_data);
      end
      step();
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ms_allowin !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release allowin=%b required 1", ms_allowin);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (dut.buf_valid !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_after buf=%b valid=%b required 0/0", dut.buf_valid, ms_to_ws_valid);
    end
    step();
  endtask

  task automatic test_flush_discard();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_in(5'd0, 32'd0, 8'd0, 6'd0, 1'b1, 1'b1, LW, 2'd0, 32'h0, 4'hF, 5'd3, 32'h3000, 32'hBFC0_0200);
    step();
    flush        = 1'b1;
    es_to_ms_bus = mk_in(5'd0, 32'd0, 8'd0, 6'd0, 1'b1, 1'b1, LW, 2'd0, 32'h0, 4'hF, 5'd4, 32'h3004, 32'hBFC0_0300);
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_valid valid=%b required 0", ms_to_ws_valid);
    end
    step();
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.discard !== 1'b1 || dut.ms_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_state discard=%b ms_valid=%b required 1/0", dut.discard, dut.ms_valid);
    end
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h11111111;
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b0 || ms_fwd_blocked !== 1'b1) begin
      n_err++;
      $display("FAIL discard_drop valid=%b blocked=%b required 0/1", ms_to_ws_valid, ms_fwd_blocked);
    end
    step();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.discard !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
      n_err++;
      $display("FAIL discard_clear discard=%b valid=%b required 0/0", dut.discard, ms_to_ws_valid);
    end
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h22222222;
    sb.push_back(mk_out(5'd0, 32'd0, 8'd0, 6'd0, 4'hF, 5'd4, 32'h22222222, 32'hBFC0_0300));
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b1) begin
      n_err++;
      $display("FAIL discard_second valid=%b required 1", ms_to_ws_valid);
    end
    step();
    data_sram_data_ok = 1'b0;
    // Flush and response in the same cycle: response belongs to the flushed load.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_in(5'd0, 32'd0, 8'd0, 6'd0, 1'b1, 1'b1, LW, 2'd0, 32'h0, 4'hF, 5'd5, 32'h3008, 32'hBFC0_0400);
    step();
    es_to_ms_valid    = 1'b0;
    flush             = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h33333333;
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_dataok valid=%b required 0", ms_to_ws_valid);
    end
    step();
    flush             = 1'b0;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.discard !== 1'b0) begin
      n_err++;
      $display("FAIL flush_dataok_discard discard=%b required 0", dut.discard);
    end
    step();
    do_load(LW, 2'd0, 32'h0, 32'h44444444, 32'h44444444, 4'hF, 0, "after_flush");
  endtask

  task automatic test_exception();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_in(5'h04, 32'hBFC0_0123, 8'h5A, 6'b110000, 1'b0, 1'b0, LW, 2'd0,
                           32'h0, 4'hF, 5'd9, 32'h1234, 32'hBFC0_0500);
    sb.push_back(mk_out(5'h04, 32'hBFC0_0123, 8'h5A, 6'b110000, 4'b0000, 5'd9, 32'h1234, 32'hBFC0_0500));
    step();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b1 || ms_ex_o !== 1'b1) begin
      n_err++;
      $display("FAIL ex_pass valid=%b ex_o=%b required 1/1", ms_to_ws_valid, ms_ex_o);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (ms_ex_o !== 1'b0) begin
      n_err++;
      $display("FAIL ex_gone ex_o=%b required 0", ms_ex_o);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_in(5'd0, 32'd0, 8'd0, 6'd0, 1'b1, 1'b1, LW, 2'd0, 32'h0, 4'hF, 5'd6, 32'h5000, 32'hBFC0_0600);
    step();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ms_fwd_blocked !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_stall blocked=%b required 1", ms_fwd_blocked);
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_dest, ms_fwd_data, ms_fwd_blocked, ms_ex_o} !== '0 ||
        dut.ms_valid !== 1'b0 || dut.buf_valid !== 1'b0 || dut.discard !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_outputs allowin=%b valid=%b bus=%h blocked=%b ms_valid=%b required all 0",
               ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_blocked, dut.ms_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loads();
    test_random_loads();
    test_back_to_back();
    test_stall_buffer();
    test_flush_discard();
    test_exception();
    test_reset_mid_stall();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover entries=%0d required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the five-stage MIPS core. Sits between EX and WB.
- Accepts instructions from EX over a valid/allowin handshake and waits for the data-SRAM response on loads.
- Extracts and merges load data (byte, half, word, lwl, lwr) and computes the final register write strobe.
- Transmits the 124-bit MS-to-WS bus to WB. Also provides forwarding/blocking and exception-kill signals to EX.

Parameters:
- ES_TO_MS_BUS_WD, 163, width of the incoming EX-to-MS bus.
- MS_TO_WS_BUS_WD, 124, width of the outgoing MS-to-WS bus.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ms_allowin  out  1  MS can accept from EX this cycle.
- es_to_ms_valid  in  1  EX presents a valid instruction.
- es_to_ms_bus  in  163  {excode[162:158], badvaddr[157:126], cp0_addr[125:118], ex[117], bd[116], eret[115], syscall[114], mfc0[113], mtc0[112], req_issued[111], load_op[110], load_type[109:107], addr_low[106:105], rt_value[104:73], gr_strb[72:69], dest[68:64], result[63:32], pc[31:0]}.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  MS presents a valid instruction to WB.
- ms_to_ws_bus  out  124  {excode[123:119], badvaddr[118:87], cp0_addr[86:79], ex[78], bd[77], eret[76], syscall[75], mfc0[74], mtc0[73], gr_strb[72:69], dest[68:64], final_result[63:32], pc[31:0]}.
- data_sram_data_ok  in  1  one-cycle pulse: read/write response returned.
- data_sram_rdata  in  32  read data, valid with data_ok.
- flush  in  1  WB exception or eret; kills the instruction in MS.
- ms_fwd_dest  out  5  dest register if ms_valid and gr_strb!=0, else 0.
- ms_fwd_data  out  32  final_result.
- ms_fwd_blocked  out  1  ms_valid & (mfc0 | (req_issued & load_op & !ms_ready_go)).
- ms_ex_o  out  1  ms_valid & (ex | eret); EX suppresses memory requests while high.

Behaviour:
- State registers:
  - ms_valid; es_to_ms_bus_r.
  - buf_valid/buf_data: response captured while stalled.
  - discard: one response owed to a flushed instruction.
- Reset: ms_valid, buf_valid, discard, ms_to_ws_valid = 0; bus register and buf_data = 0; all outputs 0.
- Response acceptance: resp_ok = data_sram_data_ok & !discard.
- ms_ready_go = ex | !req_issued | buf_valid | resp_ok.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
- Accept: if flush, ms_valid <= 0 and EX input is ignored. Else if ms_allowin, ms_valid <= es_to_ms_valid and the bus is latched on valid.
- Buffer:
  - If resp_ok while ms_valid and !(ms_ready_go & ws_allowin), set buf_valid and store rdata.
  - Clear buf_valid when the instruction leaves MS or on flush.
  - Load data source = buf_valid ? buf_data : data_sram_rdata.
- Discard:
  - On flush with ms_valid & req_issued & !buf_valid & !resp_ok, set discard.
  - The next data_sram_data_ok clears discard and is not consumed.
  - Response ordering is in-order; at most one response is ever discarded.
- Load extraction, a = addr_low, rd = load data:
  - lw (000): rd.
  - lb (001): sign-extended byte a.
  - lbu (010): zero-extended byte a.
  - lh (011): sign-extended half a[1].
  - lhu (100): zero-extended half a[1].
  - lwl (101): (rd << 8*(3-a)) | (rt_value & low (3-a) byte mask).
  - lwr (110): (rd >> 8*a) | (rt_value & high a byte mask).
- final_result = result when !load_op.
- Strobe override:
  - lwl: a=0..3 -> 1000, 1100, 1110, 1111.
  - lwr: a=0..3 -> 1111, 0111, 0011, 0001.
  - Otherwise gr_strb passes through.
  - If ex, output strobe = 0000.
- Exception fields, pc, cp0_addr, eret, syscall, mfc0 and mtc0 pass through unchanged.
- Simultaneous data_ok and flush: if discard=0, the response is treated as belonging to the flushed instruction (dropped, discard not set). If discard=1, it clears discard.

Test Plan:
- lb, a=2, rdata 0x80FF1234, ws_allowin=1, data_ok same cycle as entry -> ms_to_ws_valid=1 that cycle, final_result 0xFFFFFFFF, strb 1111.
- lhu, a=2, rdata 0x80FF1234 -> final_result 0x000080FF. lbu, a=3, same rdata -> 0x00000080.
- lwl, a=1, rt 0x11223344, rdata 0xAABBCCDD -> 0xCCDD3344, strb 1100. lwr, a=2, same rt/rdata -> 0x1122AABB, strb 0011.
- lw, data_ok arrives with ws_allowin=0 for 3 cycles, rdata 0xDEADBEEF -> buf_valid=1, ms_allowin=0, ms_fwd_blocked=0. On ws_allowin=1, outputs 0xDEADBEEF once, then buf_valid=0.
- lw issued, flush before data_ok, new lw enters next cycle -> first data_ok dropped (discard 1->0), second data_ok's rdata reaches WB. No spurious ms_to_ws_valid.
- Instruction with ex=1, excode 0x04, req_issued=0 -> passes in 1 cycle with strb 0000 and ms_ex_o=1. resetn low mid-stall -> all state and outputs 0 immediately.
